reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of reset domains, released in order of index 0 upward.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles during which all o_resetn bits are held low after a start.
REQ-003 Parameter STAGE_CYCLES, default 16: cycles between consecutive stage releases.
REQ-004 i_clock  input  1  single clock; all logic on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high block reset.
REQ-006 i_launch  input  1  sequence enable: high starts and sustains a sequence; low aborts it and releases all outputs.
REQ-007 i_sw_req  input  1  single-cycle request to re-run the sequence after completion.
REQ-008 o_resetn  output  NUM_STAGES  active-low per-domain resets; bit k drives domain k.
REQ-009 o_done  output  1  high when every stage has been released after a completed sequence.

Function
REQ-010 All outputs SHALL be registered; there is no combinational path from input to output.
REQ-011 The FSM SHALL have exactly four states: IDLE, HOLD, RELEASE, DONE.
REQ-012 IDLE: o_resetn all ones, o_done 0; i_launch=1 at an edge -> HOLD, o_resetn <= all zeros, cycle counter <= 0.
REQ-013 HOLD: o_resetn all zeros for exactly HOLD_CYCLES cycles; at the HOLD_CYCLES-th edge after entry, o_resetn[0] <= 1 and state -> RELEASE (or DONE if NUM_STAGES=1).
REQ-014 RELEASE: every STAGE_CYCLES edges, the next unreleased bit k SHALL go 1; released bits stay 1; bits are never released out of index order.
REQ-015 The edge that releases bit NUM_STAGES-1 SHALL also set o_done <= 1 and move to DONE.
REQ-016 DONE: o_resetn all ones, o_done 1; i_sw_req=1 -> HOLD with o_resetn <= all zeros, o_done <= 0, counter <= 0.
REQ-017 i_sw_req SHALL be ignored in IDLE, HOLD and RELEASE; no request is queued.
REQ-018 i_launch=0 at any edge in HOLD, RELEASE or DONE SHALL move to IDLE, with o_resetn <= all ones and o_done <= 0 on that edge.
REQ-019 i_launch=0 and i_sw_req=1 at the same edge: i_launch wins, and the next state is IDLE.
REQ-020 After an abort, a new start requires i_launch sampled high in IDLE; if i_launch is high again on the next edge, a fresh full sequence starts.
REQ-021 Cycle counter width SHALL be clog2(max(HOLD_CYCLES, STAGE_CYCLES))+1; the counter resets to 0 on every state or stage transition and never wraps inside a phase.
REQ-022 Stage index width SHALL be clog2(NUM_STAGES)+1.
REQ-023 Elaboration SHALL fail when NUM_STAGES<1, HOLD_CYCLES<1 or STAGE_CYCLES<1.

Reset
REQ-024 i_reset=1 at an edge SHALL force IDLE, o_resetn all ones, o_done 0, counter 0 and stage index 0, regardless of any other input.
REQ-025 i_reset SHALL take priority over i_launch and i_sw_req at the same edge.
REQ-026 Once i_reset deasserts, i_launch already high at the first edge SHALL start a sequence at that edge.
REQ-027 Power-up register initial values SHALL equal the i_reset values.

Verification
REQ-028 Defaults; i_launch rises and is sampled at edge E0 -> o_resetn=000 after E0; 001 at E4; 011 at E20; 111 and o_done=1 at E36.
REQ-029 Defaults; i_launch drops at E10 -> o_resetn=111 and o_done=0 after E10; relaunch at E12 -> o_resetn=000 after E12, bit0 releases at E16.
REQ-030 Defaults; sequence completes; i_sw_req pulsed at E50 -> o_resetn=000 and o_done=0 after E50, o_done=1 again at E86.
REQ-031 i_sw_req pulsed during HOLD and during RELEASE -> no effect on sequence timing; i_launch=0 with i_sw_req=1 in DONE -> IDLE.
REQ-032 i_reset asserted at E20 with i_launch=1 -> o_resetn=111 after E20; i_reset released at E25 -> new sequence starts at E25, bit0 releases at E29.
REQ-033 NUM_STAGES=1, HOLD_CYCLES=1, STAGE_CYCLES=1; launch at E0 -> o_resetn=0 after E0; o_resetn=1 and o_done=1 at E1.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES active-low reset domains.
// Holds all domains, then releases one per STAGE_CYCLES.
module reset_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 4,
  parameter int STAGE_CYCLES = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_launch,
  input  logic                  i_sw_req,
  output logic [NUM_STAGES-1:0] o_resetn,
  output logic                  o_done
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_CYCLES) ?
                        HOLD_CYCLES : STAGE_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam int SW = $clog2(NUM_STAGES) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL1 = '1;
  localparam logic [NUM_STAGES-1:0] BIT0 = NUM_STAGES'(1);

  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("NUM_STAGES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STAGE_CYCLES < 1) begin : g_bad_stage_cycles
    $error("STAGE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  state_t                state_q  = IDLE;
  logic [CW-1:0]         cnt_q    = '0;
  logic [SW-1:0]         stage_q  = '0;
  logic [NUM_STAGES-1:0] resetn_q = '1;
  logic                  done_q   = 1'b0;

  state_t                state_d;
  logic [CW-1:0]         cnt_d;
  logic [SW-1:0]         stage_d;
  logic [NUM_STAGES-1:0] resetn_d;
  logic                  done_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stage_q  <= '0;
      resetn_q <= ALL1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      resetn_q <= resetn_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    resetn_d = resetn_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        resetn_d = ALL1;
        done_d   = 1'b0;
        if (i_launch) begin
          state_d  = HOLD;
          resetn_d = '0;
          cnt_d    = '0;
          stage_d  = '0;
        end
      end
      HOLD: begin
        if (!i_launch) begin
          state_d  = IDLE;
          resetn_d = ALL1;
          done_d   = 1'b0;
          cnt_d    = '0;
          stage_d  = '0;
        end else if (cnt_q == HOLD_LAST) begin
          resetn_d = BIT0;
          cnt_d    = '0;
          stage_d  = SW'(1);
          if (NUM_STAGES == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!i_launch) begin
          state_d  = IDLE;
          resetn_d = ALL1;
          done_d   = 1'b0;
          cnt_d    = '0;
          stage_d  = '0;
        end else if (cnt_q == STAGE_LAST) begin
          // stage_q always names the lowest still-held domain
          resetn_d = resetn_q | (BIT0 << stage_q);
          cnt_d    = '0;
          stage_d  = stage_q + SW'(1);
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!i_launch) begin
          state_d  = IDLE;
          resetn_d = ALL1;
          done_d   = 1'b0;
          cnt_d    = '0;
          stage_d  = '0;
        end else if (i_sw_req) begin
          state_d  = HOLD;
          resetn_d = '0;
          done_d   = 1'b0;
          cnt_d    = '0;
          stage_d  = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        resetn_d = ALL1;
        done_d   = 1'b0;
        cnt_d    = '0;
        stage_d  = '0;
      end
    endcase
  end

  assign o_resetn = resetn_q;
  assign o_done   = done_q;

endmodule
